rc_initiator: RTL and testbench

// - Static-side initiator of the reconfiguration request/ack handshake; the PRM-side

---
 rtl/rc_pkg.sv | 17 +
 rtl/rc_initiator_if.sv | 34 +++
 rtl/rc_cnt.sv | 28 ++
 rtl/rc_initiator.sv | 150 +++++++++++++++
 tb/tb_rc_initiator.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/rc_pkg.sv
// Shared state encoding and error codes for the reconfiguration initiator.
package rc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_DL   = 3'd2,
        ST_HOLD = 3'd3,
        ST_REL  = 3'd4,
        ST_ERR  = 3'd5
    } rc_state_t;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_ACK_TO = 2'b01;
    localparam logic [1:0] ERR_DL     = 2'b10;

endpackage

// File: rtl/rc_initiator_if.sv
// Bundles the controller, PRM sync-block and bitstream-loader signals of one region.
// master = the initiator's view, slave = the environment driving it.
interface rc_initiator_if #(
    parameter int RM_ID_W = 4
) ();

    logic               rc_start;
    logic [RM_ID_W-1:0] rc_rm_id;
    logic               rc_busy;
    logic               rc_done;
    logic               rc_error;
    logic [1:0]         rc_err_code;
    logic               rc_reqn;
    logic               rc_ackn;
    logic               prm_rstn;
    logic               prm_isolate;
    logic               dl_start;
    logic [RM_ID_W-1:0] dl_rm_id;
    logic               dl_done;
    logic               dl_err;

    modport master (
        input  rc_start, rc_rm_id, rc_ackn, dl_done, dl_err,
        output rc_busy, rc_done, rc_error, rc_err_code, rc_reqn,
               prm_rstn, prm_isolate, dl_start, dl_rm_id
    );

    modport slave (
        output rc_start, rc_rm_id, rc_ackn, dl_done, dl_err,
        input  rc_busy, rc_done, rc_error, rc_err_code, rc_reqn,
               prm_rstn, prm_isolate, dl_start, dl_rm_id
    );

endinterface

// File: rtl/rc_cnt.sv
// Saturating clear/enable up-counter; tc is a combinational compare of the current count
// against TERM. No backpressure: clr has priority over en, count holds at all-ones.
module rc_cnt #(
    parameter int W    = 8,
    parameter int TERM = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [W-1:0] TERM_V = W'(TERM);

    logic [W-1:0] q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (en && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

    assign tc = (q == TERM_V);

endmodule

// File: rtl/rc_initiator.sv
// Static-side initiator of the PR request/ack swap; rc_done follows dl_done by RST_HOLD+1 cycles.
// No backpressure: commands are only accepted in IDLE/ERR, other inputs are ignored outside their state.
module rc_initiator
    import rc_pkg::*;
#(
    parameter int RM_ID_W     = 4,
    parameter int ACK_TIMEOUT = 1024,
    parameter int TO_W        = 16,
    parameter int RST_HOLD    = 4
) (
    input  logic           clk,
    input  logic           rst,
    rc_initiator_if.master bus
);

    localparam int HOLD_W  = $clog2(RST_HOLD + 1);
    localparam int TO_TERM = (ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1;

    if (ACK_TIMEOUT >= (1 << TO_W)) begin : g_bad_timeout
        $error("rc_initiator: ACK_TIMEOUT does not fit in TO_W bits");
    end
    if (RST_HOLD < 1) begin : g_bad_hold
        $error("rc_initiator: RST_HOLD must be at least 1");
    end

    rc_state_t          state;
    logic               busy_q;
    logic               done_q;
    logic               error_q;
    logic [1:0]         err_code_q;
    logic               reqn_q;
    logic               rstn_q;
    logic               iso_q;
    logic               dl_start_q;
    logic [RM_ID_W-1:0] rm_id_q;

    logic to_tc;
    logic hold_tc;
    logic ack_to;

    // Both counters restart from zero on every entry into their state.
    rc_cnt #(.W(TO_W), .TERM(TO_TERM)) u_ack_cnt (
        .clk (clk),
        .rst (rst),
        .clr (state != ST_REQ),
        .en  (state == ST_REQ),
        .tc  (to_tc)
    );

    rc_cnt #(.W(HOLD_W), .TERM(RST_HOLD - 1)) u_hold_cnt (
        .clk (clk),
        .rst (rst),
        .clr (state != ST_HOLD),
        .en  (state == ST_HOLD),
        .tc  (hold_tc)
    );

    assign ack_to = (ACK_TIMEOUT != 0) && to_tc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
            reqn_q     <= 1'b1;
            rstn_q     <= 1'b1;
            iso_q      <= 1'b0;
            dl_start_q <= 1'b0;
            rm_id_q    <= '0;
        end else begin
            dl_start_q <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.rc_start) begin
                        rm_id_q    <= bus.rc_rm_id;
                        err_code_q <= ERR_NONE;
                        reqn_q     <= 1'b0;
                        busy_q     <= 1'b1;
                        state      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // Ack beats a coincident timeout; dropping reqn with the ack keeps
                    // the responder from re-entering its ack state.
                    if (!bus.rc_ackn) begin
                        reqn_q     <= 1'b1;
                        iso_q      <= 1'b1;
                        rstn_q     <= 1'b0;
                        dl_start_q <= 1'b1;
                        state      <= ST_DL;
                    end else if (ack_to) begin
                        reqn_q     <= 1'b1;
                        error_q    <= 1'b1;
                        err_code_q <= ERR_ACK_TO;
                        busy_q     <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                ST_DL: begin
                    if (bus.dl_err) begin
                        error_q    <= 1'b1;
                        err_code_q <= ERR_DL;
                        state      <= ST_ERR;
                    end else if (bus.dl_done) begin
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (hold_tc) begin
                        rstn_q <= 1'b1;
                        state  <= ST_REL;
                    end
                end
                ST_REL: begin
                    iso_q  <= 1'b0;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                ST_ERR: begin
                    // Region is still quiesced and isolated, so retry goes straight to download.
                    if (bus.rc_start) begin
                        rm_id_q    <= bus.rc_rm_id;
                        err_code_q <= ERR_NONE;
                        dl_start_q <= 1'b1;
                        state      <= ST_DL;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.rc_busy     = busy_q;
    assign bus.rc_done     = done_q;
    assign bus.rc_error    = error_q;
    assign bus.rc_err_code = err_code_q;
    assign bus.rc_reqn     = reqn_q;
    assign bus.prm_rstn    = rstn_q;
    assign bus.prm_isolate = iso_q;
    assign bus.dl_start    = dl_start_q;
    assign bus.dl_rm_id    = rm_id_q;

endmodule

// File: tb/tb_rc_initiator.sv
// Directed vector table plus hand-written timing sequences for rc_initiator.
module tb_rc_initiator;

    typedef struct packed {
        logic       rst;
        logic       start;
        logic [3:0] id;
        logic       ackn;
        logic       done;
        logic       err;
    } vin_t;

    typedef struct packed {
        logic       busy;
        logic       reqn;
        logic       rstn;
        logic       iso;
        logic       dls;
        logic       rdone;
        logic       rerr;
        logic [1:0] code;
        logic [3:0] id;
    } vout_t;

    typedef struct packed {
        vin_t  i;
        vout_t o;
    } vec_t;

    localparam int NV = 23;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    vec_t tbl [NV];

    rc_initiator_if #(.RM_ID_W(4)) bus ();

    rc_initiator #(
        .RM_ID_W     (4),
        .ACK_TIMEOUT (16),
        .TO_W        (16),
        .RST_HOLD    (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic s, input logic [3:0] id,
                                input logic ak, input logic dd, input logic de,
                                input logic busy, input logic reqn, input logic rstn,
                                input logic iso, input logic dls, input logic rd,
                                input logic re, input logic [1:0] code, input logic [3:0] oid);
        vec_t v;
        v.i = '{rst: r, start: s, id: id, ackn: ak, done: dd, err: de};
        v.o = '{busy: busy, reqn: reqn, rstn: rstn, iso: iso, dls: dls,
                rdone: rd, rerr: re, code: code, id: oid};
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vin_t v);
        rst          = v.rst;
        bus.rc_start = v.start;
        bus.rc_rm_id = v.id;
        bus.rc_ackn  = v.ackn;
        bus.dl_done  = v.done;
        bus.dl_err   = v.err;
    endtask

    task automatic idle_inputs();
        drive('{rst: 1'b0, start: 1'b0, id: 4'd0, ackn: 1'b1, done: 1'b0, err: 1'b0});
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cmp_all(input string tag, input vout_t e);
        cmp({tag, ".busy"},     32'(bus.rc_busy),     32'(e.busy));
        cmp({tag, ".reqn"},     32'(bus.rc_reqn),     32'(e.reqn));
        cmp({tag, ".prm_rstn"}, 32'(bus.prm_rstn),    32'(e.rstn));
        cmp({tag, ".isolate"},  32'(bus.prm_isolate), 32'(e.iso));
        cmp({tag, ".dl_start"}, 32'(bus.dl_start),    32'(e.dls));
        cmp({tag, ".rc_done"},  32'(bus.rc_done),     32'(e.rdone));
        cmp({tag, ".rc_error"}, 32'(bus.rc_error),    32'(e.rerr));
        cmp({tag, ".err_code"}, 32'(bus.rc_err_code), 32'(e.code));
        cmp({tag, ".dl_rm_id"}, 32'(bus.dl_rm_id),    32'(e.id));
    endtask

    task automatic do_reset();
        drive('{rst: 1'b1, start: 1'b0, id: 4'd0, ackn: 1'b1, done: 1'b0, err: 1'b0});
        tick();
        idle_inputs();
    endtask

    initial begin
        // rst start id ackn done err | busy reqn rstn iso dls done err code id
        tbl[0]  = mk(1,0,4'd0,1,0,0, 0,1,1,0,0,0,0,2'b00,4'd0); // reset state
        tbl[1]  = mk(0,0,4'd0,1,0,0, 0,1,1,0,0,0,0,2'b00,4'd0);
        tbl[2]  = mk(0,0,4'd0,0,0,0, 0,1,1,0,0,0,0,2'b00,4'd0); // stray ack in IDLE
        tbl[3]  = mk(0,1,4'd7,1,0,0, 1,0,1,0,0,0,0,2'b00,4'd7); // start -> REQ
        tbl[4]  = mk(0,0,4'd0,0,0,0, 1,1,0,1,1,0,0,2'b00,4'd7); // ack -> DL
        tbl[5]  = mk(0,1,4'd2,1,0,0, 1,1,0,1,0,0,0,2'b00,4'd7); // start ignored in DL
        tbl[6]  = mk(0,0,4'd0,0,0,0, 1,1,0,1,0,0,0,2'b00,4'd7); // ack ignored in DL
        tbl[7]  = mk(0,0,4'd0,1,1,1, 1,1,0,1,0,0,1,2'b10,4'd7); // done+err -> ERR
        tbl[8]  = mk(0,0,4'd0,1,0,0, 1,1,0,1,0,0,0,2'b10,4'd7);
        tbl[9]  = mk(0,0,4'd0,1,1,0, 1,1,0,1,0,0,0,2'b10,4'd7); // done ignored in ERR
        tbl[10] = mk(0,1,4'd5,1,0,0, 1,1,0,1,1,0,0,2'b00,4'd5); // retry, no new request
        tbl[11] = mk(0,0,4'd0,1,1,0, 1,1,0,1,0,0,0,2'b00,4'd5); // done -> HOLD
        tbl[12] = mk(0,0,4'd0,1,0,0, 1,1,0,1,0,0,0,2'b00,4'd5);
        tbl[13] = mk(0,0,4'd0,1,0,0, 1,1,0,1,0,0,0,2'b00,4'd5);
        tbl[14] = mk(0,0,4'd0,1,0,0, 1,1,0,1,0,0,0,2'b00,4'd5);
        tbl[15] = mk(0,0,4'd0,1,0,0, 1,1,1,1,0,0,0,2'b00,4'd5); // reset released
        tbl[16] = mk(0,0,4'd0,1,0,0, 0,1,1,0,0,1,0,2'b00,4'd5); // isolate off + done
        tbl[17] = mk(0,0,4'd0,1,0,0, 0,1,1,0,0,0,0,2'b00,4'd5);
        tbl[18] = mk(0,1,4'd9,1,0,0, 1,0,1,0,0,0,0,2'b00,4'd9);
        tbl[19] = mk(0,0,4'd0,0,0,0, 1,1,0,1,1,0,0,2'b00,4'd9);
        tbl[20] = mk(1,0,4'd0,1,0,0, 0,1,1,0,0,0,0,2'b00,4'd0); // reset mid-DL
        tbl[21] = mk(0,0,4'd0,1,1,0, 0,1,1,0,0,0,0,2'b00,4'd0); // late dl_done ignored
        tbl[22] = mk(0,0,4'd0,1,0,0, 0,1,1,0,0,0,0,2'b00,4'd0);

        idle_inputs();
        rst = 1'b1;
        tick();

        for (int k = 0; k < NV; k++) begin
            drive(tbl[k].i);
            tick();
            cmp_all($sformatf("vec%0d", k), tbl[k].o);
        end
        idle_inputs();

        // Nominal swap: ack 5 cycles after reqn falls, dl_done 20 cycles after dl_start.
        do_reset();
        bus.rc_start = 1'b1; bus.rc_rm_id = 4'd3;
        tick();
        bus.rc_start = 1'b0;
        cmp("nom.reqn_low", 32'(bus.rc_reqn), 32'd0);
        for (int k = 0; k < 4; k++) tick();
        cmp("nom.wait_reqn", 32'(bus.rc_reqn), 32'd0);
        bus.rc_ackn = 1'b0;
        tick();
        bus.rc_ackn = 1'b1;
        cmp_all("nom.ack", '{busy: 1, reqn: 1, rstn: 0, iso: 1, dls: 1, rdone: 0,
                              rerr: 0, code: 2'b00, id: 4'd3});
        for (int k = 0; k < 19; k++) tick();
        cmp("nom.dl_wait_rstn", 32'(bus.prm_rstn), 32'd0);
        cmp("nom.dl_start_once", 32'(bus.dl_start), 32'd0);
        bus.dl_done = 1'b1;
        tick();
        bus.dl_done = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            cmp($sformatf("nom.hold%0d_rstn", k), 32'(bus.prm_rstn), 32'd0);
        end
        tick();
        cmp("nom.rstn_release", 32'(bus.prm_rstn), 32'd1);
        cmp("nom.iso_still_on", 32'(bus.prm_isolate), 32'd1);
        cmp("nom.no_early_done", 32'(bus.rc_done), 32'd0);
        tick();
        cmp("nom.iso_off", 32'(bus.prm_isolate), 32'd0);
        cmp("nom.rc_done", 32'(bus.rc_done), 32'd1);
        cmp("nom.busy_off", 32'(bus.rc_busy), 32'd0);
        tick();
        cmp("nom.done_pulse", 32'(bus.rc_done), 32'd0);

        // Ack timeout: error on the 16th REQ cycle, code held afterwards.
        do_reset();
        bus.rc_start = 1'b1; bus.rc_rm_id = 4'd4;
        tick();
        bus.rc_start = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (bus.rc_error !== 1'b0 || bus.rc_reqn !== 1'b0) begin
                cmp($sformatf("to.early%0d_err_reqn", k),
                    {30'd0, bus.rc_error, bus.rc_reqn}, 32'd0);
            end
        end
        cmp("to.pre_reqn", 32'(bus.rc_reqn), 32'd0);
        tick();
        cmp_all("to.abort", '{busy: 0, reqn: 1, rstn: 1, iso: 0, dls: 0, rdone: 0,
                              rerr: 1, code: 2'b01, id: 4'd4});
        tick();
        cmp("to.err_pulse", 32'(bus.rc_error), 32'd0);
        cmp("to.code_held", 32'(bus.rc_err_code), 32'd1);

        // Ack arriving on the 16th REQ cycle wins over the timeout.
        do_reset();
        bus.rc_start = 1'b1; bus.rc_rm_id = 4'd6;
        tick();
        bus.rc_start = 1'b0;
        for (int k = 0; k < 15; k++) tick();
        bus.rc_ackn = 1'b0;
        tick();
        bus.rc_ackn = 1'b1;
        cmp_all("race.ack", '{busy: 1, reqn: 1, rstn: 0, iso: 1, dls: 1, rdone: 0,
                              rerr: 0, code: 2'b00, id: 4'd6});
        tick();
        cmp("race.no_late_err", 32'(bus.rc_error), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
